bcd_cnt_n: RTL and testbench



---
 rtl/bcd_cnt_n.sv | 93 +++++++++
 tb/tb_bcd_cnt_n.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_cnt_n.sv
// Multi-digit BCD up/down counter with parallel load, wrap or saturate at the range ends,
// a registered roll-over pulse and a registered invalid-load flag.
module bcd_cnt_n #(
   parameter int unsigned DIGITS   = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  ce,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic [4*DIGITS-1:0]   qout,
   output logic                  tc,
   output logic                  roll,
   output logic                  load_err
);

   logic [4*DIGITS-1:0] cnt_q;
   logic [4*DIGITS-1:0] cnt_step;
   logic [4*DIGITS-1:0] din_fix;
   logic                all9;
   logic                all0;
   logic                din_bad;
   logic                roll_q;
   logic                load_err_q;

   always_comb begin
      all9 = 1'b1;
      all0 = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (cnt_q[4*i +: 4] != 4'd9) all9 = 1'b0;
         if (cnt_q[4*i +: 4] != 4'd0) all0 = 1'b0;
      end
      tc = up ? all9 : all0;
   end

   // Ripple the carry/borrow through the decades; a digit moves only while
   // every lower digit sits at the end value for the current direction.
   always_comb begin
      logic       chain;
      logic [3:0] d;
      chain    = 1'b1;
      cnt_step = cnt_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         d = cnt_q[4*i +: 4];
         if (chain) begin
            if (up) begin
               cnt_step[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
               chain              = (d == 4'd9);
            end else begin
               cnt_step[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
               chain              = (d == 4'd0);
            end
         end
      end
      if (SATURATE && tc) cnt_step = cnt_q;
   end

   always_comb begin
      din_fix = din;
      din_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (din[4*i +: 4] > 4'd9) begin
            din_fix[4*i +: 4] = 4'd0;
            din_bad           = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q      <= '0;
         roll_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         roll_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (load) begin
            cnt_q      <= din_fix;
            load_err_q <= din_bad;
         end else if (ce) begin
            cnt_q  <= cnt_step;
            roll_q <= tc;
         end
      end
   end

   assign qout     = cnt_q;
   assign roll     = roll_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_cnt_n.sv
// Bench for bcd_cnt_n: wrap and saturate instances share stimulus and are checked against
// an integer-valued reference model of the decimal count.
module tb_bcd_cnt_n;

   localparam int DIGITS = 4;
   localparam int MAXV   = 9999;

   logic        clk = 1'b0;
   logic        clr, ce, up, load;
   logic [15:0] din;
   logic [15:0] qout_w, qout_s;
   logic        tc_w, tc_s, roll_w, roll_s, lerr_w, lerr_s;

   int n_checks = 0;
   int n_fail   = 0;

   int mval  [2];
   bit mroll [2];
   bit mlerr [2];

   always #5 clk = ~clk;

   bcd_cnt_n #(.DIGITS(DIGITS), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .clr(clr), .ce(ce), .up(up), .load(load), .din(din),
      .qout(qout_w), .tc(tc_w), .roll(roll_w), .load_err(lerr_w)
   );

   bcd_cnt_n #(.DIGITS(DIGITS), .SATURATE(1'b1)) u_sat (
      .clk(clk), .clr(clr), .ce(ce), .up(up), .load(load), .din(din),
      .qout(qout_s), .tc(tc_s), .roll(roll_s), .load_err(lerr_s)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x           = x / 10;
      end
      return r;
   endfunction

   task automatic model_step(input int s, input logic c, input logic l, input logic e,
                             input logic u, input logic [15:0] d);
      int  v;
      int  w;
      bit  bad;
      bit  at_end;
      logic [3:0] nib;
      logic [15:0] dv;
      if (c) begin
         mval[s] = 0; mroll[s] = 0; mlerr[s] = 0;
      end else if (l) begin
         v = 0; w = 1; bad = 0; dv = d;
         for (int i = 0; i < DIGITS; i++) begin
            nib = dv[4*i +: 4];
            if (nib > 9) bad = 1;
            else v = v + int'(nib) * w;
            w = w * 10;
         end
         mval[s] = v; mroll[s] = 0; mlerr[s] = bad;
      end else begin
         mlerr[s] = 0;
         mroll[s] = 0;
         if (e) begin
            at_end   = u ? (mval[s] == MAXV) : (mval[s] == 0);
            mroll[s] = at_end;
            if (at_end) begin
               if (s == 0) mval[s] = u ? 0 : MAXV;
            end else begin
               mval[s] = u ? mval[s] + 1 : mval[s] - 1;
            end
         end
      end
   endtask

   task automatic step(input logic c, input logic l, input logic e, input logic u,
                       input logic [15:0] d, input string tag);
      bit tcx;
      clr = c; load = l; ce = e; up = u; din = d;
      @(posedge clk);
      model_step(0, c, l, e, u, d);
      model_step(1, c, l, e, u, d);
      #1;
      check_val({tag, " qout_wrap"}, 32'(qout_w), 32'(to_bcd(mval[0])));
      check_val({tag, " roll_wrap"}, 32'(roll_w), 32'(mroll[0]));
      check_val({tag, " lerr_wrap"}, 32'(lerr_w), 32'(mlerr[0]));
      tcx = u ? (mval[0] == MAXV) : (mval[0] == 0);
      check_val({tag, " tc_wrap"}, 32'(tc_w), 32'(tcx));
      check_val({tag, " qout_sat"}, 32'(qout_s), 32'(to_bcd(mval[1])));
      check_val({tag, " roll_sat"}, 32'(roll_s), 32'(mroll[1]));
      check_val({tag, " lerr_sat"}, 32'(lerr_s), 32'(mlerr[1]));
      tcx = u ? (mval[1] == MAXV) : (mval[1] == 0);
      check_val({tag, " tc_sat"}, 32'(tc_s), 32'(tcx));
   endtask

   initial begin
      logic        rc, rl, re, ru;
      logic [15:0] rd;
      int          r;

      step(1, 0, 0, 1, 16'h0000, "init_clr");

      // Reset overrides a simultaneous load
      step(0, 1, 0, 1, 16'h0120, "ld_0120");
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0000, "cnt_to_0123");
      check_val("at_0123", 32'(qout_w), 32'h0123);
      step(1, 1, 1, 1, 16'h5555, "clr_over_load");
      check_val("clr_zero", 32'(qout_w), 32'h0000);

      // Up wrap / saturate at the top
      step(0, 1, 0, 1, 16'h9998, "ld_9998");
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0000, "up_end");
      check_val("wrap_0001", 32'(qout_w), 32'h0001);
      check_val("sat_9999", 32'(qout_s), 32'h9999);
      step(0, 0, 1, 0, 16'h0000, "sat_down");

      // Borrow chain and tc right after a load
      step(0, 1, 0, 0, 16'h1000, "ld_1000");
      step(0, 0, 1, 0, 16'h0000, "borrow");
      check_val("borrow_0999", 32'(qout_w), 32'h0999);
      step(0, 1, 0, 0, 16'h0000, "ld_0000_tc");
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 16'h0000, "down_end");

      // Invalid digit load, then load beating ce
      step(0, 1, 0, 1, 16'h12A4, "ld_invalid");
      check_val("inv_1204", 32'(qout_w), 32'h1204);
      step(0, 0, 0, 1, 16'h0000, "lerr_clear");
      step(0, 1, 1, 1, 16'h0042, "load_wins");

      // Hold with ce low while up toggles
      step(0, 1, 0, 0, 16'h0000, "ld_zero");
      for (int i = 0; i < 10; i++) step(0, 0, 0, logic'(i % 2), 16'h0000, "hold");

      ru = 1'b1;
      for (int n = 0; n < 400; n++) begin
         r  = int'($urandom_range(0, 99));
         rc = (r < 2);
         rl = (r >= 2 && r < 10);
         re = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) ru = ~ru;
         case ($urandom_range(0, 3))
            0:       rd = 16'h9997;
            1:       rd = 16'h0002;
            2:       rd = 16'($urandom);
            default: rd = to_bcd(int'($urandom_range(0, MAXV)));
         endcase
         step(rc, rl, re, ru, rd, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
